// File: rtl/bsg_fifo_1r1w_one_hot_ptr_if.sv
// Ready/valid handshake bundle for the one-hot pointer FIFO.
// The slave modport is the FIFO side. The master modport is the producer/consumer side.
interface bsg_fifo_1r1w_one_hot_ptr_if #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 16
);
  logic               clear_i;
  logic               v_i;
  logic [width_p-1:0] data_i;
  logic               ready_o;
  logic               v_o;
  logic [width_p-1:0] data_o;
  logic               yumi_i;
  logic [els_p-1:0]   wptr_o;
  logic [els_p-1:0]   rptr_o;

  modport slave (
    input  clear_i, v_i, data_i, yumi_i,
    output ready_o, v_o, data_o, wptr_o, rptr_o
  );

  modport master (
    output clear_i, v_i, data_i, yumi_i,
    input  ready_o, v_o, data_o, wptr_o, rptr_o
  );
endinterface

// File: rtl/bsg_fifo_1r1w_one_hot_ptr.sv
// Shallow single-clock ready/valid FIFO.
// Rotating one-hot read and write pointers drive the storage row selects directly.
module bsg_fifo_1r1w_one_hot_ptr #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 16
) (
  input logic                          clk_i,
  input logic                          reset_n_i,
  bsg_fifo_1r1w_one_hot_ptr_if.slave   fifo_if
);

  localparam logic [els_p-1:0] PtrInit = {{(els_p-1){1'b0}}, 1'b1};

  logic [els_p-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [els_p-1:0]   wptr_rotl, rptr_rotl;
  logic               full_q, full_d, empty_q, empty_d;
  logic               enq, deq;
  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] rd_data;

  // A full FIFO ignores v_i, and an empty FIFO ignores yumi_i.
  assign enq = fifo_if.v_i & ~full_q;
  assign deq = fifo_if.yumi_i & ~empty_q;

  assign wptr_rotl = {wptr_q[els_p-2:0], wptr_q[els_p-1]};
  assign rptr_rotl = {rptr_q[els_p-2:0], rptr_q[els_p-1]};

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    if (fifo_if.clear_i) begin
      wptr_d  = PtrInit;
      rptr_d  = PtrInit;
      full_d  = 1'b0;
      empty_d = 1'b1;
    end else begin
      if (enq) wptr_d = wptr_rotl;
      if (deq) rptr_d = rptr_rotl;
      // Equal pointers are ambiguous; the last operation tells full from empty.
      if (enq && !deq) begin
        empty_d = 1'b0;
        full_d  = (wptr_rotl == rptr_q);
      end else if (deq && !enq) begin
        full_d  = 1'b0;
        empty_d = (rptr_rotl == wptr_q);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= PtrInit;
      rptr_q  <= PtrInit;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage holds no reset value. Only the row selected by wptr is written.
  always_ff @(posedge clk_i) begin
    if (enq && !fifo_if.clear_i) begin
      for (int i = 0; i < els_p; i++) begin
        if (wptr_q[i]) mem_q[i] <= fifo_if.data_i;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < els_p; i++) begin
      rd_data = rd_data | (mem_q[i] & {width_p{rptr_q[i]}});
    end
  end

  assign fifo_if.ready_o = ~full_q;
  assign fifo_if.v_o     = ~empty_q;
  assign fifo_if.data_o  = rd_data;
  assign fifo_if.wptr_o  = wptr_q;
  assign fifo_if.rptr_o  = rptr_q;

`ifndef SYNTHESIS
  a_wptr_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i) $onehot(wptr_q));
  a_rptr_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i) $onehot(rptr_q));
`endif

endmodule

// File: tb/tb_bsg_fifo_1r1w_one_hot_ptr.sv
// Scoreboard bench for the one-hot pointer FIFO (els_p=4, width_p=8).
// A queue and pointer model track the expected state; outputs are sampled on the falling edge.
module tb_bsg_fifo_1r1w_one_hot_ptr;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic clk_i;
  logic reset_n_i;

  bsg_fifo_1r1w_one_hot_ptr_if #(.width_p(W), .els_p(N)) fif ();

  bsg_fifo_1r1w_one_hot_ptr #(.width_p(W), .els_p(N)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .fifo_if   (fif)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [W-1:0] m_q [$];
  logic [N-1:0] m_wp, m_rp;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rotl(input logic [N-1:0] p);
    return {p[N-2:0], p[N-1]};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_wp = 4'b0001;
    m_rp = 4'b0001;
  endtask

  task automatic check_outputs();
    check_eq("ready_o", 32'(fif.ready_o), 32'(m_q.size() < N));
    check_eq("v_o", 32'(fif.v_o), 32'(m_q.size() != 0));
    check_eq("wptr_o", 32'(fif.wptr_o), 32'(m_wp));
    check_eq("rptr_o", 32'(fif.rptr_o), 32'(m_rp));
    if (m_q.size() != 0) check_eq("data_o", 32'(fif.data_o), 32'(m_q[0]));
  endtask

  // One clock cycle: check state, drive inputs, then advance the model at the rising edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic y, input logic clr);
    logic do_enq, do_deq;
    @(negedge clk_i);
    check_outputs();
    fif.v_i     = v;
    fif.data_i  = d;
    fif.yumi_i  = y;
    fif.clear_i = clr;
    if (y) check_eq("yumi_legal", 32'(fif.v_o), 32'd1);
    @(posedge clk_i);
    if (clr) begin
      model_reset();
    end else begin
      do_enq = v && (m_q.size() < N);
      do_deq = y && (m_q.size() != 0);
      if (do_deq) begin
        void'(m_q.pop_front());
        m_rp = rotl(m_rp);
      end
      if (do_enq) begin
        m_q.push_back(d);
        m_wp = rotl(m_wp);
      end
    end
  endtask

  initial begin
    reset_n_i   = 1'b0;
    fif.v_i     = 1'b0;
    fif.data_i  = '0;
    fif.yumi_i  = 1'b0;
    fif.clear_i = 1'b0;
    model_reset();

    @(negedge clk_i);
    check_outputs();
    reset_n_i = 1'b1;

    // Fill to full, then offer more data while full.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);

    // Drain completely.
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Steady-state concurrent enqueue and dequeue at occupancy 2.
    step(1'b1, 8'hF0, 1'b0, 1'b0);
    step(1'b1, 8'hF1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // A clear beats a simultaneous write.
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset between clock edges.
    step(1'b1, 8'h61, 1'b0, 1'b0);
    step(1'b1, 8'h62, 1'b0, 1'b0);
    fif.v_i = 1'b0;
    #2;
    reset_n_i = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_v_o", 32'(fif.v_o), 32'd0);
    check_eq("async_rst_ready_o", 32'(fif.ready_o), 32'd1);
    check_eq("async_rst_wptr_o", 32'(fif.wptr_o), 32'(m_wp));
    check_eq("async_rst_rptr_o", 32'(fif.rptr_o), 32'(m_rp));
    @(negedge clk_i);
    reset_n_i = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic with occasional clears.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 1)) && (m_q.size() != 0),
           ($urandom_range(0, 199) == 0));
    end
    while (m_q.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
